hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard and forwarding unit for the in-order MIPS pipeline, successor to the fixed three-stage hazard block. It generates per-operand forwarding selects for NSRC decode-stage sources from NFWD downstream stages, and decode/fetch stalls. It also keeps a register scoreboard that tracks up to LONG_MAX outstanding long-latency writes (divider, multiplier), plus a CP0 gap counter. It sits beside the decode stage, takes status from EX/MEM/WB and the long-latency unit, and drives the decode-operand muxes and the pipeline allowin logic.

## Interface
- NREG, 32: architectural GPR count; AW = clog2(NREG).
- NSRC, 2: source operands per decode instruction.
- NFWD, 3: forwarding stages, index 0 = youngest (EX), NFWD-1 = oldest (WB).
- BR_MIN_STAGE, 1: branches in ID may forward only from stage index >= this.
- LONG_MAX, 2: maximum outstanding long-latency writes; CW = clog2(LONG_MAX+1).
- CP0_GAP, 3: fetch-stall cycles after a CP0 instruction leaves ID.
- SELW = clog2(NFWD+1).
- clk  in  1  pipeline clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ds_raddr  in  NSRC*AW  source register numbers, operand i at [i*AW +: AW].
- ds_rd_en  in  NSRC  operand i actually read.
- ds_is_branch  in  1  instruction resolves in ID (needs operands this cycle).
- ds_dest  in  AW  destination register.
- ds_gr_we  in  1  instruction writes ds_dest.
- ds_long  in  1  instruction's GPR result comes from the long-latency unit.
- ds_is_cp0  in  1  mfc0/mtc0/eret.
- ds_go  in  1  instruction leaves ID this cycle.
- st_valid  in  NFWD  stage holds a valid instruction.
- st_gr_we  in  NFWD  stage writes a GPR.
- st_dest  in  NFWD*AW  stage destination.
- st_ready  in  NFWD  stage result is forwardable (0 for a load in EX, or for mfc0 before MEM).
- long_done  in  1  long-latency unit writes long_dest this cycle.
- long_dest  in  AW  register being written by the long-latency unit.
- flush  in  1  exception/eret flush.
- fwd_sel  out  NSRC*SELW  0 = regfile, k = stage k-1.
- stall_d  out  1  hold ID, inject bubble into EX.
- stall_f  out  1  hold IF.
- sb_busy  out  1  any scoreboard bit set.

## Operation
- Per operand i, when ds_rd_en[i] and raddr != 0: match = lowest stage index k with st_valid & st_gr_we & st_dest == raddr. Younger stages win over older ones.
- Match with st_ready[k]=1 and (!ds_is_branch or k >= BR_MIN_STAGE): fwd_sel = k+1.
- Match with st_ready[k]=0, or a branch matching k < BR_MIN_STAGE: stall_d=1 and fwd_sel = 0.
- No match: fwd_sel = 0. raddr = 0 or rd_en = 0 always gives sel 0 and no stall contribution.
- Scoreboard pending[NREG]:
  - RAW stall: any read operand with pending[raddr] = 1.
  - WAW stall: ds_gr_we with pending[ds_dest] = 1.
  - Capacity stall: ds_long when outstanding count == LONG_MAX.
- Issue event: ds_go & !stall_d. A ds_go during stall_d=1 is ignored and causes no state update.
- Issue with ds_long & ds_gr_we & dest != 0 sets pending[dest] and increments count. Issue with ds_long and no GPR write (HI/LO) increments count only.
- long_done clears pending[long_dest] and decrements count. Set and clear of the same register in one cycle: set wins. Simultaneous increment and decrement: count unchanged. A decrement at 0 saturates.
- CP0 gap: an issue with ds_is_cp0 loads cp0_cnt = CP0_GAP. cp0_cnt decrements to 0; stall_f = 1 while cp0_cnt != 0. A reload while nonzero restarts the count.
- stall_f also asserts whenever stall_d = 1.
- flush: clears pending, count and cp0_cnt at the next edge; flush has priority over same-cycle issue and done.
- sb_busy = |pending.

## Timing
- fwd_sel, stall_d and stall_f are combinational from current inputs and state, valid in the same cycle.
- Scoreboard and counter updates become visible the cycle after the issue, done or flush edge.
- A long_done in cycle t still stalls a reader in cycle t; the reader proceeds in t+1 and reads the regfile with sel 0 (WB write-through).
- Reset (resetn=0, asynchronous): pending = 0, count = 0, cp0_cnt = 0. With all inputs low: fwd_sel = 0, stall_d = 0, stall_f = 0, sb_busy = 0. Reset mid-operation discards all outstanding state immediately.

## Test plan
- ALU chain, defaults: EX st_dest=5 (ready) and WB st_dest=5, ds_raddr op0=5 -> fwd_sel op0 = 1 (EX wins), no stall.
- Load-use: EX load dest=8 with st_ready=0, op1=8 -> stall_d = stall_f = 1. Next cycle, with the load in MEM and ready -> fwd_sel op1 = 2, no stall.
- Branch in ID, EX ready dest=3, op0=3 -> stall_d=1. Same register in MEM -> sel 2, no stall.
- Long op: issue div (ds_long, dest=10), then a reader of r10 -> stall until long_done with dest=10; released the following cycle with sel 0. A third long issue while count=2 -> stall_d=1.
- CP0: issue mfc0 -> stall_f high for exactly 3 cycles with stall_d=0. Flush mid-count -> stall_f drops after 1 edge and sb_busy = 0.
- Reset asserted with pending[7]=1 and cp0_cnt=2 -> all outputs 0 immediately. A ds_go during stall_d=1 sets no pending bit.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode/stage status bundle for the hazard scoreboard.
//   master : pipeline side, drives decode-stage operand info, downstream stage
//            status, long-latency completion and flush; observes selects/stalls.
//   slave  : scoreboard side, the mirror of master.
// ds_raddr packs operand i at [i*AW +: AW]; st_dest packs stage k at [k*AW +: AW];
// fwd_sel packs operand i at [i*SELW +: SELW].
interface hazard_scoreboard_if #(
  parameter int unsigned NREG = 32,
  parameter int unsigned NSRC = 2,
  parameter int unsigned NFWD = 3
);
  localparam int unsigned AW   = $clog2(NREG);
  localparam int unsigned SELW = $clog2(NFWD + 1);

  logic [NSRC*AW-1:0]   ds_raddr;
  logic [NSRC-1:0]      ds_rd_en;
  logic                 ds_is_branch;
  logic [AW-1:0]        ds_dest;
  logic                 ds_gr_we;
  logic                 ds_long;
  logic                 ds_is_cp0;
  logic                 ds_go;
  logic [NFWD-1:0]      st_valid;
  logic [NFWD-1:0]      st_gr_we;
  logic [NFWD*AW-1:0]   st_dest;
  logic [NFWD-1:0]      st_ready;
  logic                 long_done;
  logic [AW-1:0]        long_dest;
  logic                 flush;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 stall_d;
  logic                 stall_f;
  logic                 sb_busy;

  modport master (
    output ds_raddr, ds_rd_en, ds_is_branch, ds_dest, ds_gr_we, ds_long, ds_is_cp0, ds_go,
    output st_valid, st_gr_we, st_dest, st_ready, long_done, long_dest, flush,
    input  fwd_sel, stall_d, stall_f, sb_busy
  );

  modport slave (
    input  ds_raddr, ds_rd_en, ds_is_branch, ds_dest, ds_gr_we, ds_long, ds_is_cp0, ds_go,
    input  st_valid, st_gr_we, st_dest, st_ready, long_done, long_dest, flush,
    output fwd_sel, stall_d, stall_f, sb_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding-select and stall generation for the decode stage,
// with a scoreboard of outstanding long-latency GPR writes and a CP0 fetch gap.
// Ports:
//   clk    : pipeline clock, all state on the rising edge
//   resetn : asynchronous active-low reset
//   bus    : hazard_scoreboard_if.slave (decode operands, stage status,
//            long-latency completion, flush in; fwd_sel/stall_d/stall_f/sb_busy out)
module hazard_scoreboard #(
  parameter int unsigned NREG         = 32,
  parameter int unsigned NSRC         = 2,
  parameter int unsigned NFWD         = 3,
  parameter int unsigned BR_MIN_STAGE = 1,
  parameter int unsigned LONG_MAX     = 2,
  parameter int unsigned CP0_GAP      = 3
) (
  input  logic               clk,
  input  logic               resetn,
  hazard_scoreboard_if.slave bus
);
  localparam int unsigned AW   = $clog2(NREG);
  localparam int unsigned SELW = $clog2(NFWD + 1);
  localparam int unsigned CW   = $clog2(LONG_MAX + 1);
  localparam int unsigned GW   = $clog2(CP0_GAP + 1);

  logic [NREG-1:0]      pending_q, pending_d;
  logic [CW-1:0]        count_q, count_d;
  logic [GW-1:0]        cp0_cnt_q, cp0_cnt_d;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 fwd_stall, raw_stall, waw_stall, cap_stall;
  logic                 stall_d, issue, cnt_inc, cnt_dec;

  // Per-operand producer search; the first hit in index order is the youngest.
  always_comb begin : fwd_search
    logic [AW-1:0] raddr;
    logic          hit;
    fwd_sel   = '0;
    fwd_stall = 1'b0;
    raw_stall = 1'b0;
    raddr     = '0;
    hit       = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      raddr = bus.ds_raddr[i*AW +: AW];
      hit   = 1'b0;
      if (bus.ds_rd_en[i] && raddr != '0) begin
        if (pending_q[raddr]) raw_stall = 1'b1;
        for (int k = 0; k < NFWD; k++) begin
          if (!hit && bus.st_valid[k] && bus.st_gr_we[k] &&
              bus.st_dest[k*AW +: AW] == raddr) begin
            hit = 1'b1;
            // Branches resolve in ID, so the EX result arrives too late for them.
            if (bus.st_ready[k] && (!bus.ds_is_branch || k >= int'(BR_MIN_STAGE))) begin
              fwd_sel[i*SELW +: SELW] = SELW'(k + 1);
            end else begin
              fwd_stall = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    waw_stall = bus.ds_gr_we && pending_q[bus.ds_dest];
    cap_stall = bus.ds_long && (count_q == CW'(LONG_MAX));
    stall_d   = fwd_stall || raw_stall || waw_stall || cap_stall;
    issue     = bus.ds_go && !stall_d;
    cnt_inc   = issue && bus.ds_long;
    cnt_dec   = bus.long_done;
  end

  always_comb begin
    pending_d = pending_q;
    count_d   = count_q;
    cp0_cnt_d = cp0_cnt_q;
    if (bus.flush) begin
      pending_d = '0;
      count_d   = '0;
      cp0_cnt_d = '0;
    end else begin
      if (bus.long_done) pending_d[bus.long_dest] = 1'b0;
      // Applied after the clear so a same-register set wins.
      if (issue && bus.ds_long && bus.ds_gr_we && bus.ds_dest != '0) begin
        pending_d[bus.ds_dest] = 1'b1;
      end
      if (cnt_inc && !cnt_dec) begin
        count_d = count_q + CW'(1);
      end else if (cnt_dec && !cnt_inc && count_q != '0) begin
        count_d = count_q - CW'(1);
      end
      if (issue && bus.ds_is_cp0) begin
        cp0_cnt_d = GW'(CP0_GAP);
      end else if (cp0_cnt_q != '0) begin
        cp0_cnt_d = cp0_cnt_q - GW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q <= '0;
      count_q   <= '0;
      cp0_cnt_q <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      cp0_cnt_q <= cp0_cnt_d;
    end
  end

  assign bus.fwd_sel = fwd_sel;
  assign bus.stall_d = stall_d;
  assign bus.stall_f = stall_d || (cp0_cnt_q != '0);
  assign bus.sb_busy = |pending_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic, each cycle
// compared against a behavioural model of the forwarding and scoreboard rules.
module tb_hazard_scoreboard;
  localparam int NREG     = 32;
  localparam int NSRC     = 2;
  localparam int NFWD     = 3;
  localparam int BR_MIN   = 1;
  localparam int LONG_MAX = 2;
  localparam int CP0_GAP  = 3;
  localparam int AW       = 5;
  localparam int SELW     = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_errs = 0;

  hazard_scoreboard_if #(.NREG(NREG), .NSRC(NSRC), .NFWD(NFWD)) bus ();

  hazard_scoreboard #(
    .NREG(NREG), .NSRC(NSRC), .NFWD(NFWD), .BR_MIN_STAGE(BR_MIN),
    .LONG_MAX(LONG_MAX), .CP0_GAP(CP0_GAP)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model state
  bit m_pend[NREG];
  int m_cnt;
  int m_cp0;
  int exp_sel[NSRC];
  bit exp_sd, exp_sf, exp_busy;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[r]) m_pend[r] = 1'b0;
    m_cnt = 0;
    m_cp0 = 0;
  endtask

  task automatic model_eval();
    int r, k;
    exp_sd = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      exp_sel[i] = 0;
      r = int'(bus.ds_raddr[i*AW +: AW]);
      if (bus.ds_rd_en[i] && r != 0) begin
        if (m_pend[r]) exp_sd = 1'b1;
        k = -1;
        // Scan oldest to youngest so the youngest producer is left in k.
        for (int s = NFWD - 1; s >= 0; s--) begin
          if (bus.st_valid[s] && bus.st_gr_we[s] && int'(bus.st_dest[s*AW +: AW]) == r) k = s;
        end
        if (k >= 0) begin
          if (bus.st_ready[k] && !(bus.ds_is_branch && k < BR_MIN)) exp_sel[i] = k + 1;
          else exp_sd = 1'b1;
        end
      end
    end
    if (bus.ds_gr_we && m_pend[int'(bus.ds_dest)]) exp_sd = 1'b1;
    if (bus.ds_long && m_cnt == LONG_MAX) exp_sd = 1'b1;
    exp_sf = exp_sd || (m_cp0 > 0);
    exp_busy = 1'b0;
    foreach (m_pend[r2]) if (m_pend[r2]) exp_busy = 1'b1;
  endtask

  task automatic model_update();
    bit iss;
    int delta;
    iss = bus.ds_go && !exp_sd;
    if (bus.flush) begin
      model_reset();
      return;
    end
    if (bus.long_done) m_pend[int'(bus.long_dest)] = 1'b0;
    if (iss && bus.ds_long && bus.ds_gr_we && bus.ds_dest != 0) m_pend[int'(bus.ds_dest)] = 1'b1;
    delta = ((iss && bus.ds_long) ? 1 : 0) - (bus.long_done ? 1 : 0);
    m_cnt = m_cnt + delta;
    if (m_cnt < 0) m_cnt = 0;
    if (iss && bus.ds_is_cp0) m_cp0 = CP0_GAP;
    else if (m_cp0 > 0) m_cp0 = m_cp0 - 1;
  endtask

  // Called just after inputs are driven at the falling edge.
  task automatic settle_check();
    #1;
    model_eval();
    for (int i = 0; i < NSRC; i++) begin
      check_val($sformatf("sel%0d", i), 32'(bus.fwd_sel[i*SELW +: SELW]), 32'(exp_sel[i]));
    end
    check_val("stall_d", 32'(bus.stall_d), 32'(exp_sd));
    check_val("stall_f", 32'(bus.stall_f), 32'(exp_sf));
    check_val("sb_busy", 32'(bus.sb_busy), 32'(exp_busy));
  endtask

  task automatic advance();
    model_update();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    bus.ds_raddr = '0; bus.ds_rd_en = '0; bus.ds_is_branch = 1'b0;
    bus.ds_dest = '0; bus.ds_gr_we = 1'b0; bus.ds_long = 1'b0;
    bus.ds_is_cp0 = 1'b0; bus.ds_go = 1'b0;
    bus.st_valid = '0; bus.st_gr_we = '0; bus.st_dest = '0; bus.st_ready = '0;
    bus.long_done = 1'b0; bus.long_dest = '0; bus.flush = 1'b0;
  endtask

  task automatic set_st(input int k, input int d, input bit rdy);
    bus.st_valid[k] = 1'b1;
    bus.st_gr_we[k] = 1'b1;
    bus.st_dest[k*AW +: AW] = AW'(d);
    bus.st_ready[k] = rdy;
  endtask

  task automatic set_op(input int i, input int r);
    bus.ds_raddr[i*AW +: AW] = AW'(r);
    bus.ds_rd_en[i] = 1'b1;
  endtask

  task automatic issue_long(input int d, input bit we, input bit cp0);
    clr_inputs();
    bus.ds_long = 1'b1; bus.ds_gr_we = we; bus.ds_dest = AW'(d);
    bus.ds_is_cp0 = cp0; bus.ds_go = 1'b1;
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear at once.
  task automatic pulse_reset(input string tag);
    clr_inputs();
    #1;
    resetn = 1'b0;
    #1;
    model_reset();
    check_val({tag, "_sel"}, 32'(bus.fwd_sel), 32'd0);
    check_val({tag, "_stall_d"}, 32'(bus.stall_d), 32'd0);
    check_val({tag, "_stall_f"}, 32'(bus.stall_f), 32'd0);
    check_val({tag, "_busy"}, 32'(bus.sb_busy), 32'd0);
    #1;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    clr_inputs();
    for (int i = 0; i < NSRC; i++) begin
      bus.ds_raddr[i*AW +: AW] = AW'($urandom_range(0, 7));
      bus.ds_rd_en[i] = ($urandom_range(0, 3) != 0);
    end
    bus.ds_is_branch = ($urandom_range(0, 3) == 0);
    bus.ds_dest = AW'($urandom_range(0, 7));
    bus.ds_gr_we = $urandom_range(0, 1) == 1;
    bus.ds_long = ($urandom_range(0, 3) == 0);
    bus.ds_is_cp0 = ($urandom_range(0, 15) == 0);
    bus.ds_go = ($urandom_range(0, 3) != 0);
    for (int k = 0; k < NFWD; k++) begin
      bus.st_valid[k] = $urandom_range(0, 1) == 1;
      bus.st_gr_we[k] = $urandom_range(0, 1) == 1;
      bus.st_dest[k*AW +: AW] = AW'($urandom_range(0, 7));
      bus.st_ready[k] = ($urandom_range(0, 3) != 0);
    end
    bus.long_done = ($urandom_range(0, 3) == 0);
    bus.long_dest = AW'($urandom_range(0, 7));
    bus.flush = ($urandom_range(0, 31) == 0);
  endtask

  initial begin
    clr_inputs();
    model_reset();
    // Reset state with inputs low
    #2;
    check_val("rst_sel", 32'(bus.fwd_sel), 32'd0);
    check_val("rst_stall_d", 32'(bus.stall_d), 32'd0);
    check_val("rst_stall_f", 32'(bus.stall_f), 32'd0);
    check_val("rst_busy", 32'(bus.sb_busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // ALU chain: EX and WB both write r5, EX wins
    clr_inputs(); set_st(0, 5, 1'b1); set_st(2, 5, 1'b1); set_op(0, 5);
    settle_check();
    check_val("alu_sel0", 32'(bus.fwd_sel[SELW-1:0]), 32'd1);
    check_val("alu_stall", 32'(bus.stall_d), 32'd0);
    advance();

    // Load-use: stall, then forward from MEM
    clr_inputs(); set_st(0, 8, 1'b0); set_op(1, 8);
    settle_check();
    check_val("lu_stall_d", 32'(bus.stall_d), 32'd1);
    check_val("lu_stall_f", 32'(bus.stall_f), 32'd1);
    advance();
    clr_inputs(); set_st(1, 8, 1'b1); set_op(1, 8);
    settle_check();
    check_val("lu_sel1", 32'(bus.fwd_sel[2*SELW-1:SELW]), 32'd2);
    check_val("lu_nostall", 32'(bus.stall_d), 32'd0);
    advance();

    // Branch cannot take the EX result
    clr_inputs(); bus.ds_is_branch = 1'b1; set_st(0, 3, 1'b1); set_op(0, 3);
    settle_check();
    check_val("br_stall", 32'(bus.stall_d), 32'd1);
    advance();
    clr_inputs(); bus.ds_is_branch = 1'b1; set_st(1, 3, 1'b1); set_op(0, 3);
    settle_check();
    check_val("br_sel0", 32'(bus.fwd_sel[SELW-1:0]), 32'd2);
    check_val("br_nostall", 32'(bus.stall_d), 32'd0);
    advance();

    // Long op on r10, reader stalls through the done cycle
    issue_long(10, 1'b1, 1'b0);
    settle_check(); advance();
    clr_inputs(); set_op(0, 10); bus.ds_go = 1'b1;
    settle_check();
    check_val("long_raw", 32'(bus.stall_d), 32'd1);
    check_val("long_busy", 32'(bus.sb_busy), 32'd1);
    advance();
    bus.long_done = 1'b1; bus.long_dest = AW'(10);
    settle_check();
    check_val("long_done_stall", 32'(bus.stall_d), 32'd1);
    advance();
    clr_inputs(); set_op(0, 10); bus.ds_go = 1'b1;
    settle_check();
    check_val("long_release", 32'(bus.stall_d), 32'd0);
    check_val("long_sel0", 32'(bus.fwd_sel[SELW-1:0]), 32'd0);
    advance();
    // Capacity: two HI/LO long ops fill the counter
    issue_long(0, 1'b0, 1'b0); settle_check(); advance();
    issue_long(0, 1'b0, 1'b0); settle_check(); advance();
    issue_long(12, 1'b1, 1'b0);
    settle_check();
    check_val("cap_stall", 32'(bus.stall_d), 32'd1);
    advance();
    clr_inputs(); bus.flush = 1'b1; settle_check(); advance();

    // CP0 gap of three cycles
    clr_inputs(); bus.ds_is_cp0 = 1'b1; bus.ds_go = 1'b1;
    settle_check(); advance();
    clr_inputs();
    for (int c = 0; c < CP0_GAP; c++) begin
      settle_check();
      check_val($sformatf("cp0_f%0d", c), 32'(bus.stall_f), 32'd1);
      check_val($sformatf("cp0_d%0d", c), 32'(bus.stall_d), 32'd0);
      advance();
    end
    settle_check();
    check_val("cp0_end", 32'(bus.stall_f), 32'd0);
    advance();
    // Flush mid-count with a pending long write
    issue_long(4, 1'b1, 1'b1); settle_check(); advance();
    clr_inputs(); settle_check();
    check_val("fl_pre_busy", 32'(bus.sb_busy), 32'd1);
    advance();
    bus.flush = 1'b1; settle_check(); advance();
    clr_inputs(); settle_check();
    check_val("fl_stall_f", 32'(bus.stall_f), 32'd0);
    check_val("fl_busy", 32'(bus.sb_busy), 32'd0);
    advance();

    // Reset with pending[7] set and cp0_cnt at 2
    issue_long(7, 1'b1, 1'b1); settle_check(); advance();
    clr_inputs(); settle_check(); advance();
    check_val("pre_rst_busy", 32'(bus.sb_busy), 32'd1);
    check_val("pre_rst_f", 32'(bus.stall_f), 32'd1);
    pulse_reset("midrst");

    // ds_go while stalled must not set a pending bit
    issue_long(9, 1'b1, 1'b0); set_st(0, 6, 1'b0); set_op(0, 6);
    settle_check();
    check_val("ign_stall", 32'(bus.stall_d), 32'd1);
    advance();
    clr_inputs(); settle_check();
    check_val("ign_busy", 32'(bus.sb_busy), 32'd0);
    advance();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) pulse_reset("rand_rst");
      rand_inputs();
      settle_check();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
